alu_control_mc: RTL and testbench
=================================

Name: alu_control_mc

Overview:
Registered, parametrised ALU control unit for the pipelined datapath. It decodes funct_i/ALUOp_i into an ALU operation code one cycle after acceptance. It sequences multi-cycle multiply operations: it holds the control code, stalls upstream with stall_o, and flags completion with valid_o. It sits between the ID/EX register and the ALU/multiplier, and stall_o feeds the hazard unit.

Parameters:
CTRL_W, 4, width of ALUCtrl_o (minimum 3); codes are zero-extended to this width.
MUL_LAT, 4, total cycles from multiply acceptance to result-valid (minimum 1).
CNT_W, $clog2(MUL_LAT)+1, width of the internal latency counter (derived; do not override).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
valid_i  in  1  funct_i/ALUOp_i are valid this cycle.
funct_i  in  6  R-type funct field.
ALUOp_i  in  2  main-control ALU op class.
flush_i  in  1  synchronous abort of the current and any in-flight operation.
ALUCtrl_o  out  CTRL_W  registered ALU operation code.
valid_o  out  1  ALUCtrl_o is final this cycle; the result may be consumed.
stall_o  out  1  registered; upstream must hold its inputs and not advance.
mul_start_o  out  1  one-cycle pulse to the multiplier on the first cycle of a multiply.

Behaviour:
- Decode table (ALUCtrl_o value):
  - ALUOp 00: ADD = 1.
  - ALUOp 01: SUB = 2.
  - ALUOp 11: OR = 4.
  - ALUOp 10, decoded on funct: 100000 ADD = 1; 100010 SUB = 2; 100100 AND = 3; 100101 OR = 4; 011000 MUL = 5; 101010 SLT = 6; any other funct = 0 (NOP).
- Only ALUOp 10 with funct 011000 is a multiply. Every other op is single-cycle.
- Reset (rst_i = 1 at an edge): ALUCtrl_o = 0, valid_o = 0, stall_o = 0, mul_start_o = 0, counter = 0, state = IDLE. Reset overrides all other inputs.
- States:
  - IDLE: no operation in flight.
  - BUSY: multiply in flight, counter > 0.
- Acceptance: an edge with valid_i = 1, stall_o = 0, flush_i = 0.
- Single-cycle op accepted: next cycle ALUCtrl_o = code, valid_o = 1, stall_o = 0. Latency is 1. Back-to-back acceptance every cycle is allowed.
- No acceptance while in IDLE: valid_o = 0, ALUCtrl_o holds its last value, mul_start_o = 0.
- Multiply accepted, MUL_LAT > 1:
  - Next cycle: ALUCtrl_o = 5, mul_start_o = 1, valid_o = 0, stall_o = 1, counter = MUL_LAT-1, state = BUSY.
  - Each following BUSY cycle: counter decrements; mul_start_o = 0; ALUCtrl_o stays 5.
  - Edge where the counter goes 1 -> 0: state = IDLE, stall_o = 0, valid_o = 1.
  - Net effect: stall_o is high for exactly MUL_LAT-1 cycles, and valid_o rises MUL_LAT cycles after acceptance.
- Multiply with MUL_LAT = 1: identical to a single-cycle op, with mul_start_o = 1 and valid_o = 1 in the same cycle; stall_o never asserts.
- While BUSY, valid_i and the decode inputs are ignored (no acceptance). Upstream holds them because stall_o = 1.
- The cycle valid_o = 1 for a multiply has stall_o = 0, so a new op may be accepted at that edge. There is no bubble between a multiply and the next op.
- flush_i = 1 at an edge (and no reset):
  - state = IDLE, counter = 0, valid_o = 0, stall_o = 0, mul_start_o = 0; ALUCtrl_o holds its value.
  - A valid_i in the same cycle is dropped (flush wins).
- Reset or flush mid-multiply: the multiply is abandoned; no valid_o is produced for it.
- Counter never underflows; it is only loaded on multiply acceptance.

Test Plan:
1. Reset: assert rst_i for 2 cycles with valid_i = 1 -> ALUCtrl_o = 0, valid_o = 0, stall_o = 0, mul_start_o = 0 throughout.
2. Back-to-back single-cycle ops:
   - Stimulus, one per cycle: ALUOp 00; ALUOp 01; ALUOp 10/100100; ALUOp 10/101010; ALUOp 10/111111.
   - Required: ALUCtrl_o = 1, 2, 3, 6, 0 on consecutive cycles, each one cycle later, with valid_o = 1 each cycle and stall_o = 0.
3. Multiply, MUL_LAT = 4: accept ALUOp 10/011000 at edge 0, then an ADD held on the inputs ->
   - Cycle 1: mul_start_o = 1.
   - Cycles 1-3: stall_o = 1, valid_o = 0, ALUCtrl_o = 5.
   - Cycle 4: valid_o = 1, stall_o = 0.
   - Cycle 5: ALUCtrl_o = 1, valid_o = 1.
4. Flush mid-multiply: assert flush_i in cycle 2 of a multiply together with valid_i = 1 (SUB) -> from cycle 3: stall_o = 0 and valid_o = 0; no valid_o for either the multiply or the SUB; ALUCtrl_o remains 5.
5. Synchronous reset mid-multiply in cycle 2 -> cycle 3: ALUCtrl_o = 0, stall_o = 0, valid_o = 0; the next accepted OR yields ALUCtrl_o = 4, valid_o = 1 one cycle later.
6. MUL_LAT = 1, CTRL_W = 6: multiply accepted -> next cycle ALUCtrl_o = 6'b000101, mul_start_o = 1, valid_o = 1, stall_o never asserts.

Source files
------------

// File: rtl/alu_control_mc_if.sv
// Request/response bundle between the ID/EX stage and the ALU control unit.
interface alu_control_mc_if #(
  parameter int CTRL_W = 4
);
  logic              valid_i;
  logic [5:0]        funct_i;
  logic [1:0]        ALUOp_i;
  logic              flush_i;
  logic [CTRL_W-1:0] ALUCtrl_o;
  logic              valid_o;
  logic              stall_o;
  logic              mul_start_o;

  modport master (
    output valid_i, funct_i, ALUOp_i, flush_i,
    input  ALUCtrl_o, valid_o, stall_o, mul_start_o
  );

  modport slave (
    input  valid_i, funct_i, ALUOp_i, flush_i,
    output ALUCtrl_o, valid_o, stall_o, mul_start_o
  );
endinterface

// File: rtl/alu_control_mc.sv
// Registered ALU control decode with multi-cycle multiply sequencing.
module alu_control_mc #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = $clog2(MUL_LAT) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_control_mc_if.slave  bus
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;

  // A multiply only needs the BUSY sequence when it takes more than one cycle.
  localparam logic MULTI_CYCLE = (MUL_LAT > 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              stall_q, stall_d;
  logic              mul_start_q, mul_start_d;

  logic              accept;
  logic              is_mul;
  logic [2:0]        code;

  function automatic logic [2:0] decode(input logic [1:0] op, input logic [5:0] funct);
    logic [2:0] r;
    r = OP_NOP;
    case (op)
      2'b00: r = OP_ADD;
      2'b01: r = OP_SUB;
      2'b11: r = OP_OR;
      default: begin
        case (funct)
          6'b100000: r = OP_ADD;
          6'b100010: r = OP_SUB;
          6'b100100: r = OP_AND;
          6'b100101: r = OP_OR;
          6'b011000: r = OP_MUL;
          6'b101010: r = OP_SLT;
          default:   r = OP_NOP;
        endcase
      end
    endcase
    return r;
  endfunction

  assign code   = decode(bus.ALUOp_i, bus.funct_i);
  assign is_mul = (bus.ALUOp_i == 2'b10) && (bus.funct_i == 6'b011000);
  assign accept = bus.valid_i && !stall_q && !bus.flush_i && (state_q == IDLE);

  // State, counter and registered outputs; reset dominates everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      valid_q     <= 1'b0;
      stall_q     <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      stall_q     <= stall_d;
      mul_start_q <= mul_start_d;
    end
  end

  // Next state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && is_mul && MULTI_CYCLE) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Next values of the registered outputs; the code register only changes on acceptance.
  always_comb begin
    ctrl_d      = ctrl_q;
    valid_d     = 1'b0;
    stall_d     = 1'b0;
    mul_start_d = 1'b0;
    if (!bus.flush_i) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ctrl_d      = CTRL_W'(code);
            mul_start_d = is_mul;
            if (is_mul && MULTI_CYCLE) begin
              stall_d = 1'b1;
            end else begin
              valid_d = 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_q <= CNT_W'(1)) begin
            valid_d = 1'b1;
          end else begin
            stall_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ALUCtrl_o   = ctrl_q;
  assign bus.valid_o     = valid_q;
  assign bus.stall_o     = stall_q;
  assign bus.mul_start_o = mul_start_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed-vector bench for alu_control_mc (MUL_LAT=4/CTRL_W=4 and MUL_LAT=1/CTRL_W=6).
module tb_alu_control_mc;

  logic clk_i;
  logic rst_i;
  int unsigned n_vec;
  int unsigned n_err;

  alu_control_mc_if #(.CTRL_W(4)) bus0 ();
  alu_control_mc_if #(.CTRL_W(6)) bus1 ();

  alu_control_mc #(.CTRL_W(4), .MUL_LAT(4)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus0.slave)
  );

  alu_control_mc #(.CTRL_W(6), .MUL_LAT(1)) u_dut1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus1.slave)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ctrl, input logic valid,
                           input logic stall, input logic mstart);
    check({tag, ".ctrl"},  32'(bus0.ALUCtrl_o),   32'(ctrl));
    check({tag, ".valid"}, 32'(bus0.valid_o),     32'(valid));
    check({tag, ".stall"}, 32'(bus0.stall_o),     32'(stall));
    check({tag, ".mst"},   32'(bus0.mul_start_o), 32'(mstart));
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
    bus0.valid_i = v;
    bus0.ALUOp_i = op;
    bus0.funct_i = f;
  endtask

  logic [1:0] t2_op  [5];
  logic [5:0] t2_fn  [5];
  logic [3:0] t2_exp [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    t2_op[0] = 2'b00; t2_fn[0] = 6'b000000; t2_exp[0] = 4'd1;
    t2_op[1] = 2'b01; t2_fn[1] = 6'b000000; t2_exp[1] = 4'd2;
    t2_op[2] = 2'b10; t2_fn[2] = 6'b100100; t2_exp[2] = 4'd3;
    t2_op[3] = 2'b10; t2_fn[3] = 6'b101010; t2_exp[3] = 4'd6;
    t2_op[4] = 2'b10; t2_fn[4] = 6'b111111; t2_exp[4] = 4'd0;

    rst_i = 1'b1;
    bus0.flush_i = 1'b0;
    drive(1'b1, 2'b00, 6'b000000);
    bus1.valid_i = 1'b1;
    bus1.ALUOp_i = 2'b10;
    bus1.funct_i = 6'b011000;
    bus1.flush_i = 1'b0;

    // 1. Reset with valid_i asserted.
    step();
    check_all("rst_c1", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("rst_c2", 4'd0, 1'b0, 1'b0, 1'b0);
    check("rst_u1.ctrl",  32'(bus1.ALUCtrl_o),   32'd0);
    check("rst_u1.mst",   32'(bus1.mul_start_o), 32'd0);
    rst_i = 1'b0;
    bus1.valid_i = 1'b0;

    // 2. Back-to-back single-cycle ops.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, t2_op[i], t2_fn[i]);
      step();
      check_all($sformatf("b2b%0d", i), t2_exp[i], 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 2'b00, 6'b000000);
    step();
    check_all("idle_hold", 4'd0, 1'b0, 1'b0, 1'b0);

    // 3. Multiply with an ADD held behind it.
    drive(1'b1, 2'b10, 6'b011000);
    step();
    check_all("mul_c1", 4'd5, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 2'b00, 6'b000000);
    step();
    check_all("mul_c2", 4'd5, 1'b0, 1'b1, 1'b0);
    step();
    check_all("mul_c3", 4'd5, 1'b0, 1'b1, 1'b0);
    step();
    check_all("mul_c4", 4'd5, 1'b1, 1'b0, 1'b0);
    step();
    check_all("mul_c5", 4'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 6'b000000);
    step();
    check_all("mul_c6", 4'd1, 1'b0, 1'b0, 1'b0);

    // 4. Flush in cycle 2 of a multiply together with a SUB.
    drive(1'b1, 2'b10, 6'b011000);
    step();
    check_all("fl_c1", 4'd5, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 2'b10, 6'b011000);
    step();
    check_all("fl_c2", 4'd5, 1'b0, 1'b1, 1'b0);
    bus0.flush_i = 1'b1;
    drive(1'b1, 2'b01, 6'b000000);
    step();
    check_all("fl_c3", 4'd5, 1'b0, 1'b0, 1'b0);
    bus0.flush_i = 1'b0;
    drive(1'b0, 2'b00, 6'b000000);
    step();
    check_all("fl_c4", 4'd5, 1'b0, 1'b0, 1'b0);
    step();
    check_all("fl_c5", 4'd5, 1'b0, 1'b0, 1'b0);

    // 5. Reset in cycle 2 of a multiply, then an OR.
    drive(1'b1, 2'b10, 6'b011000);
    step();
    check_all("rm_c1", 4'd5, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 2'b00, 6'b000000);
    step();
    check_all("rm_c2", 4'd5, 1'b0, 1'b1, 1'b0);
    rst_i = 1'b1;
    step();
    check_all("rm_c3", 4'd0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    drive(1'b1, 2'b11, 6'b000000);
    step();
    check_all("rm_or", 4'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 6'b000000);
    step();
    check_all("rm_idle", 4'd4, 1'b0, 1'b0, 1'b0);

    // 6. MUL_LAT = 1, CTRL_W = 6: multiply completes like a single-cycle op.
    bus1.valid_i = 1'b1;
    bus1.ALUOp_i = 2'b10;
    bus1.funct_i = 6'b011000;
    step();
    check("m1_c1.ctrl",  32'(bus1.ALUCtrl_o),   32'h05);
    check("m1_c1.mst",   32'(bus1.mul_start_o), 32'd1);
    check("m1_c1.valid", 32'(bus1.valid_o),     32'd1);
    check("m1_c1.stall", 32'(bus1.stall_o),     32'd0);
    bus1.ALUOp_i = 2'b10;
    bus1.funct_i = 6'b100010;
    step();
    check("m1_c2.ctrl",  32'(bus1.ALUCtrl_o),   32'h02);
    check("m1_c2.mst",   32'(bus1.mul_start_o), 32'd0);
    check("m1_c2.valid", 32'(bus1.valid_o),     32'd1);
    check("m1_c2.stall", 32'(bus1.stall_o),     32'd0);
    bus1.valid_i = 1'b0;
    step();
    check("m1_c3.valid", 32'(bus1.valid_o),     32'd0);
    check("m1_c3.ctrl",  32'(bus1.ALUCtrl_o),   32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
